sram_mem_controller: RTL and testbench

- Memory-stage backing-store controller that sits directly downstream of the MEM stage.
- Consumes the MEM stage's read/write request (ALU result as address, Rm value as write data).
- Performs each 32-bit word access as two 16-bit accesses to an external SRAM with a fixed number of wait states.
- Returns read data, and holds ready low so the pipeline freezes until the access completes.

---
 rtl/sram_mem_controller_if.sv | 24 ++
 rtl/sram_mem_controller.sv | 85 ++++++++
 tb/tb_sram_mem_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if: pipeline request/response plus SRAM half-word bus
interface sram_mem_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: splits each 32-bit MEM-stage access into two wait-stated 16-bit SRAM accesses
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input logic                  clk,
    input logic                  rst,
    sram_mem_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [16:0] w_q;
    logic [15:0] wdata_hi_q;
    logic [15:0] low_q;
    logic [31:0] read_data_q;
    logic [17:0] sram_addr_q;
    logic [15:0] dq_out_q;
    logic        oe_q;
    logic        we_n_q;
    logic        req;
    logic [16:0] w;

    assign req = bus.rd_en | bus.wr_en;
    assign w   = 17'((bus.address - 32'(BASE_ADDR)) >> 2);

    assign bus.ready       = (state_q == IDLE && !req) || state_q == DONE;
    assign bus.read_data   = read_data_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;

    // Access sequencer; strobes are registered so they line up with the state they belong to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            w_q         <= '0;
            wdata_hi_q  <= '0;
            low_q       <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    state_q     <= LOW;
                    cnt_q       <= '0;
                    wr_q        <= bus.wr_en;
                    w_q         <= w;
                    wdata_hi_q  <= bus.write_data[31:16];
                    sram_addr_q <= {w, 1'b0};
                    dq_out_q    <= bus.write_data[15:0];
                    oe_q        <= bus.wr_en;
                    we_n_q      <= !bus.wr_en;
                end
                LOW, HIGH: if (cnt_q == LAST) begin
                    cnt_q <= '0;
                    if (state_q == LOW) begin
                        state_q     <= HIGH;
                        sram_addr_q <= {w_q, 1'b1};
                        dq_out_q    <= wdata_hi_q;
                        if (!wr_q) low_q <= bus.sram_dq_in;
                    end else begin
                        state_q <= DONE;
                        oe_q    <= 1'b0;
                        we_n_q  <= 1'b1;
                        if (!wr_q) read_data_q <= {bus.sram_dq_in, low_q};
                    end
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed checks of the SRAM controller against a small SRAM model
module tb_sram_mem_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   errs  = 0;

    sram_mem_controller_if bus();

    sram_mem_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] mem [0:15];

    // Asynchronous-read SRAM model, written while we_n is low
    always @(posedge clk) if (!bus.sram_we_n) mem[bus.sram_addr[3:0]] <= bus.sram_dq_out;
    assign bus.sram_dq_in = mem[bus.sram_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [17:0] lo, input logic [31:0] exp_rd,
                          input logic [31:0] prev_rd);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.address = addr;
        bus.write_data = wd;
        #1 chk("ready_c0", 32'(bus.ready), 0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.address = 32'hFFFF_0000;
                bus.write_data = 32'h5555_AAAA;
            end
            if (c <= 10) begin
                chk($sformatf("ready_c%0d", c), 32'(bus.ready), 0);
                chk($sformatf("addr_c%0d", c), 32'(bus.sram_addr), 32'(c <= 5 ? lo : lo + 18'd1));
                chk($sformatf("we_n_c%0d", c), 32'(bus.sram_we_n), 32'(!wr));
                chk($sformatf("oe_c%0d", c), 32'(bus.sram_dq_oe), 32'(wr));
                if (wr) chk($sformatf("dq_c%0d", c), 32'(bus.sram_dq_out), 32'(c <= 5 ? wd[15:0] : wd[31:16]));
                chk($sformatf("rd_hold_c%0d", c), bus.read_data, prev_rd);
            end else begin
                chk("ready_c11", 32'(bus.ready), 1);
                chk("we_n_c11", 32'(bus.sram_we_n), 1);
                chk("oe_c11", 32'(bus.sram_dq_oe), 0);
                chk("read_data_c11", bus.read_data, exp_rd);
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("ready_after", 32'(bus.ready), 1);
    endtask

    int t1, t2, cyc;
    logic seen;

    initial begin
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_we_n", 32'(bus.sram_we_n), 1);
        chk("rst_oe", 32'(bus.sram_dq_oe), 0);
        chk("rst_rd", bus.read_data, 0);
        chk("rst_addr", 32'(bus.sram_addr), 0);
        chk("rst_dq", 32'(bus.sram_dq_out), 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.ready), 1);
            chk("idle_we_n", 32'(bus.sram_we_n), 1);
            chk("idle_oe", 32'(bus.sram_dq_oe), 0);
            chk("idle_rd", bus.read_data, 0);
        end
        access(1, 0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0, 32'h0);
        chk("mem4", 32'(mem[4]), 32'hBEEF);
        chk("mem5", 32'(mem[5]), 32'hDEAD);
        access(0, 1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF, 32'h0);
        access(1, 1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("mem0", 32'(mem[0]), 32'h5678);
        chk("mem1", 32'(mem[1]), 32'h1234);
        access(0, 1, 32'd1027, 32'h0, 18'd0, 32'h12345678, 32'hDEADBEEF);
        // reset while the high half of a read is in flight
        rst = 1'b0;
        #1 rst = 1'b1;
        bus.rd_en = 1'b1;
        bus.address = 32'd1032;
        repeat (8) @(negedge clk);
        chk("mid_addr_high", 32'(bus.sram_addr), 5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rd", bus.read_data, 0);
        chk("mid_addr", 32'(bus.sram_addr), 0);
        chk("mid_we_n", 32'(bus.sram_we_n), 1);
        chk("mid_oe", 32'(bus.sram_dq_oe), 0);
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_ready_after", 32'(bus.ready), 1);
        chk("mid_rd_after", bus.read_data, 0);
        // back-to-back reads held across DONE
        bus.rd_en = 1'b1;
        bus.address = 32'd1032;
        t1 = -1;
        t2 = -1;
        cyc = 0;
        seen = 1'b0;
        while (cyc < 40 && t2 < 0) begin
            @(negedge clk);
            cyc++;
            if (bus.ready) begin
                if (!seen) begin
                    t1 = cyc;
                    seen = 1'b1;
                    chk("b2b_rd1", bus.read_data, 32'hDEADBEEF);
                    @(negedge clk);
                    cyc++;
                    chk("b2b_dead_ready", 32'(bus.ready), 0);
                    chk("b2b_dead_addr", 32'(bus.sram_addr), 5);
                    @(negedge clk);
                    cyc++;
                    chk("b2b_low_addr", 32'(bus.sram_addr), 4);
                    chk("b2b_low_ready", 32'(bus.ready), 0);
                end else begin
                    t2 = cyc;
                end
            end
        end
        bus.rd_en = 1'b0;
        chk("b2b_first_seen", 32'(t1 >= 0), 1);
        chk("b2b_spacing", 32'(t2 - t1), 12);
        chk("b2b_rd2", bus.read_data, 32'hDEADBEEF);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
